// File: rtl/pwm_capture.sv
// PWM input measurement: synchronises pwm_in, times rise-to-rise period and high time,
// and derives a duty code with a bit-serial restoring divider.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int DUTY_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              timeout,
    output logic              overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam int              IW        = $clog2(DUTY_W + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic              s1, s2, s3;
    logic [1:0]        warm_reg;
    logic              low_seen_reg;
    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  hi_lat_reg;

    logic              div_busy_reg;
    logic [IW-1:0]     div_iter_reg;
    logic [CNT_W-1:0]  div_rem_reg;
    logic [DUTY_W-1:0] div_quot_reg;
    logic [CNT_W-1:0]  div_period_reg;
    logic [CNT_W-1:0]  div_high_reg;

    logic              rise, fall, rise_ok;
    logic              closing, accept, to_fire;
    logic [CNT_W:0]    rem_shift;
    logic [CNT_W:0]    per_ext;
    logic              q_bit;
    logic [DUTY_W-1:0] quot_next;
    logic              last_iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // A high input at reset release looks like a rise because the flops start at 0;
    // ignore rises until the synchronised level has genuinely been seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_reg     <= 2'd0;
            low_seen_reg <= 1'b0;
        end else begin
            if (warm_reg != 2'd2)
                warm_reg <= warm_reg + 2'd1;
            if (warm_reg == 2'd2 && !s2)
                low_seen_reg <= 1'b1;
        end
    end

    assign rise_ok = rise & low_seen_reg;
    assign closing = rise_ok && (state_reg == ST_LOW);
    assign accept  = closing && !div_busy_reg;
    assign overrun = closing && div_busy_reg;
    // Fires once per stuck episode; the rise takes priority when both coincide.
    assign to_fire = (cnt_reg == TIMEOUT_C) && !rise_ok && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_lat_reg <= '0;
        end else begin
            if (rise_ok)
                cnt_reg <= CNT_W'(1);
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + CNT_W'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (rise_ok)
                        state_reg <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (to_fire) begin
                        state_reg <= ST_IDLE;
                    end else if (fall) begin
                        state_reg  <= ST_LOW;
                        hi_lat_reg <= cnt_reg;
                    end
                end
                ST_LOW: begin
                    if (rise_ok)
                        state_reg <= ST_HIGH;
                    else if (to_fire)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Restoring division of high_time * 2^DUTY_W by period, MSB first.
    assign rem_shift = {div_rem_reg, 1'b0};
    assign per_ext   = {1'b0, div_period_reg};
    assign q_bit     = (rem_shift >= per_ext);
    assign quot_next = DUTY_W'({div_quot_reg, q_bit});
    assign last_iter = (div_iter_reg == IW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_busy_reg   <= 1'b0;
            div_iter_reg   <= '0;
            div_rem_reg    <= '0;
            div_quot_reg   <= '0;
            div_period_reg <= '0;
            div_high_reg   <= '0;
            period         <= '0;
            high_time      <= '0;
            duty           <= '0;
            valid          <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (accept) begin
                div_busy_reg   <= 1'b1;
                div_iter_reg   <= IW'(DUTY_W);
                div_rem_reg    <= hi_lat_reg;
                div_quot_reg   <= '0;
                div_period_reg <= cnt_reg;
                div_high_reg   <= hi_lat_reg;
            end else if (div_busy_reg) begin
                div_rem_reg  <= q_bit ? CNT_W'(rem_shift - per_ext) : CNT_W'(rem_shift);
                div_quot_reg <= quot_next;
                div_iter_reg <= div_iter_reg - IW'(1);
                if (last_iter) begin
                    div_busy_reg <= 1'b0;
                    period       <= div_period_reg;
                    high_time    <= div_high_reg;
                    duty         <= quot_next;
                    valid        <= 1'b1;
                end
            end

            // The divider is always idle by the time a timeout can fire.
            if (to_fire) begin
                timeout   <= 1'b1;
                period    <= '0;
                high_time <= '0;
                duty      <= s2 ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
                valid     <= 1'b1;
            end else if (rise_ok) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule
